pulse_rate_meter: RTL
=====================

# pulse_rate_meter

Gated event counter that sits directly downstream of the one-shot pulse stretcher in the random-pulser chain. It counts rising edges of the stretched pulse over a fixed gate window of `GATE_CYCLES` clocks. At the end of each window it latches the count, flags saturation and issues a one-cycle valid strobe. The result gives a measured rate that can be compared against the encoder threshold driving the random generator.

## Interface
- `GATE_CYCLES`, default 1000000: length of one gate window in `clk` cycles; legal range ≥2.
- `COUNT_WIDTH`, default 16: width of the accumulator and of `count_out`.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pulse_in`  in  1  stretched pulse from the one-shot; synchronous to `clk`.
- `enable`  in  1  high = measure continuously; low = idle.
- `count_out`  out  COUNT_WIDTH  edge count of the last completed window.
- `count_valid`  out  1  one-cycle strobe when `count_out` updates.
- `overflow`  out  1  last completed window saturated.
- `busy`  out  1  high while in GATE state.
- `peak_out`  out  COUNT_WIDTH  largest `count_out` since reset; present only with `PULSE_RATE_PEAK_EN`.

## Operation
- Edge detect: `prev` register. `edge = pulse_in & ~prev`. `prev` resets to 1, so a level that is already high when reset is released is not counted.
- `prev` updates every cycle in every state.
- States:
  - IDLE: `gcnt`=0, `acc`=0, `ovf`=0.
  - IDLE→GATE when `enable`=1 is sampled.
- GATE, every cycle:
  - If `enable`=0: → IDLE, discard `acc`/`ovf`, no strobe; `count_out`/`overflow` hold.
  - Else if `gcnt`<`GATE_CYCLES`-1: `gcnt`+1, `acc` += `edge`.
  - Else (last gate cycle):
    - `count_out` ← sat(`acc`+`edge`); `overflow` ← `ovf` | carry.
    - `count_valid` ← 1; `acc`, `gcnt`, `ovf` ← 0.
    - Stay in GATE, so the next window starts the following cycle with no dead cycle.
- Saturation:
  - `acc` never wraps; at 2^COUNT_WIDTH−1 further edges set `ovf` and `acc` holds.
  - `ovf` is also set if the final-cycle edge would carry.
- One long `pulse_in` level spanning a window boundary counts once, in the window containing its rising edge.
- Simultaneous edge and last gate cycle: that edge belongs to the ending window.
- `busy` = (state==GATE).

## Timing
- Reset values: `count_out`=0, `count_valid`=0, `overflow`=0, `busy`=0, `peak_out`=0, state IDLE, `prev`=1.
- `reset` asserted mid-window: all state returns to reset values on the next edge, no strobe.
- `enable` sampled high at edge N: `busy`=1 after edge N.
- Window 1 covers cycles N+1 … N+`GATE_CYCLES`.
- `count_valid` is high for exactly one cycle, after edge N+`GATE_CYCLES`. `count_out`/`overflow` change on the same edge.
- Strobe period in steady state is exactly `GATE_CYCLES`.
- Count latency: an edge in the last gate cycle appears in `count_out` on the next clock.

## Configuration
- `PULSE_RATE_PEAK_EN` defined:
  - Adds `peak_out` register.
  - On each `count_valid` edge, `peak_out` ← max(`peak_out`, new count).
  - Cleared only by `reset`.
- Not defined: `peak_out` port and its logic are absent; all other behaviour is identical.

## Test plan
- `GATE_CYCLES`=100, `COUNT_WIDTH`=16, enable high, 1-cycle pulses every 10 cycles -> `count_valid` every 100 cycles, `count_out`=10, `overflow`=0.
- `COUNT_WIDTH`=4, 20 pulses in one window -> `count_out`=15, `overflow`=1. Next window with 3 pulses -> `count_out`=3, `overflow`=0.
- `enable` dropped at gate cycle 50 -> no strobe, `count_out` holds its previous value, `busy`=0. Re-enable -> full 100-cycle window before the next strobe.
- `pulse_in` held high from cycle 95 to cycle 110 of window 1 -> window 1 counts it once, window 2 does not.
- `reset` pulsed mid-window with `pulse_in`=1 -> all outputs 0. No edge is counted until `pulse_in` goes low and then high again.
- With `PULSE_RATE_PEAK_EN`: window counts 4, 9, 2 -> `peak_out` 4, 9, 9.

Source files
------------

// File: rtl/pulse_rate_meter.sv
// Gated rising-edge counter: counts pulse_in edges over GATE_CYCLES clocks and latches a saturating result.
// Optional peak tracking of completed window counts is built when PULSE_RATE_PEAK_EN is defined.
module pulse_rate_meter #(
  parameter int unsigned GATE_CYCLES = 1000000,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pulse_in,
  input  logic                   enable,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   count_valid,
  output logic                   overflow,
  output logic                   busy
`ifdef PULSE_RATE_PEAK_EN
  ,
  output logic [COUNT_WIDTH-1:0] peak_out
`endif
);

  localparam int unsigned GW = $clog2(GATE_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] ACC_MAX = '1;
  localparam logic [GW-1:0] LAST_CYCLE = GW'(GATE_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_GATE = 1'b1
  } state_t;

  state_t                 state;
  logic                   prev;
  logic [GW-1:0]          gcnt;
  logic [COUNT_WIDTH-1:0] acc;
  logic                   ovf;

  logic                   rise_c;
  logic                   acc_full_c;
  logic                   final_carry_c;
  logic [COUNT_WIDTH-1:0] final_c;

  // prev resets high so a level already present at reset release is not an edge
  assign rise_c        = pulse_in & ~prev;
  assign acc_full_c    = (acc == ACC_MAX);
  assign final_carry_c = rise_c & acc_full_c;
  assign final_c       = final_carry_c ? ACC_MAX : acc + COUNT_WIDTH'(rise_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      prev        <= 1'b1;
      gcnt        <= '0;
      acc         <= '0;
      ovf         <= 1'b0;
      count_out   <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
`ifdef PULSE_RATE_PEAK_EN
      peak_out    <= '0;
`endif
    end else begin
      prev        <= pulse_in;
      count_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          gcnt <= '0;
          acc  <= '0;
          ovf  <= 1'b0;
          if (enable) begin
            state <= S_GATE;
            busy  <= 1'b1;
          end
        end
        S_GATE: begin
          if (!enable) begin
            // abandoned window: results discarded, published outputs hold
            state <= S_IDLE;
            busy  <= 1'b0;
            gcnt  <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
          end else if (gcnt < LAST_CYCLE) begin
            gcnt <= gcnt + GW'(1);
            if (rise_c) begin
              if (acc_full_c) ovf <= 1'b1;
              else            acc <= acc + COUNT_WIDTH'(1);
            end
          end else begin
            // last gate cycle: publish and roll straight into the next window
            count_out   <= final_c;
            overflow    <= ovf | final_carry_c;
            count_valid <= 1'b1;
            gcnt        <= '0;
            acc         <= '0;
            ovf         <= 1'b0;
`ifdef PULSE_RATE_PEAK_EN
            if (final_c > peak_out) peak_out <= final_c;
`endif
          end
        end
      endcase
    end
  end

endmodule
